dtcore32_mem_arbiter: RTL
=========================

// Module: dtcore32_mem_arbiter
// PURPOSE
//  Shares one 32-bit memory bus between the IF stage (fetch) and the MEM stage (load/store).
//  Grants one requester at a time, drives the bus until it completes, and returns read data.
//  Data accesses have priority; a bounded-burst counter prevents starving fetch.
//  Optional bus timeout returns an error so the core can raise an access fault.
// PARAMETERS
//  MAX_D_BURST     4    consecutive data grants allowed while if_req_i is pending (>=1)
//  TIMEOUT_CYCLES  0    cycles of bus_valid_o without bus_ready_i before error; 0 = disabled
// PORTS
//  clk_i          in   1   clock
//  rst_i          in   1   synchronous active-high reset
//  if_req_i       in   1   fetch request, held with if_addr_i until if_gnt_o
//  if_addr_i      in   32  fetch address
//  if_flush_i     in   1   discard any pending/in-flight fetch response
//  if_gnt_o       out  1   fetch request accepted (combinational, IDLE only)
//  if_rvalid_o    out  1   one-cycle fetch response pulse
//  if_rdata_o     out  32  fetched instruction word
//  if_err_o       out  1   fetch timed out (valid with if_rvalid_o)
//  dmem_req_i     in   1   data request, held with operands until dmem_gnt_o
//  dmem_op_i      in   5   mem_op_t encoding (bit4 = active, bit3 = store)
//  dmem_addr_i    in   32  data address
//  dmem_wdata_i   in   32  store data, already lane-aligned
//  dmem_wmask_i   in   4   store byte mask
//  dmem_gnt_o     out  1   data request accepted
//  dmem_rvalid_o  out  1   one-cycle data completion pulse (loads and stores)
//  dmem_rdata_o   out  32  raw load word (MEM stage extracts/extends)
//  dmem_err_o     out  1   data access timed out
//  bus_valid_o    out  1   bus request
//  bus_addr_o     out  32  word-aligned address {addr[31:2],2'b00}
//  bus_we_o       out  1   1 = write
//  bus_wstrb_o    out  4   byte strobes; 4'b0000 on reads
//  bus_wdata_o    out  32  write data
//  bus_ready_i    in   1   bus completes transfer when bus_valid_o && bus_ready_i
//  bus_rdata_i    in   32  read data, valid with bus_ready_i
// BEHAVIOUR
//  - States: IDLE, BUSY_I, BUSY_D. Reset: IDLE, all outputs 0, burst/timeout counters 0.
//  - IDLE grant: dmem_req_i wins unless burst_cnt==MAX_D_BURST && if_req_i, then fetch wins.
//    Fetch is not granted in a cycle with if_flush_i=1. Granted request is latched; -> BUSY_*.
//  - burst_cnt: +1 per data grant while if_req_i=1 (saturating), cleared on any fetch grant
//    or when if_req_i=0.
//  - dmem_op_i[4]=0 when granted: no bus transfer; dmem_rvalid_o pulses the next cycle; stay IDLE.
//  - BUSY_*: bus_valid_o=1 from the cycle after grant. Addr, we, wstrb and wdata are registered
//    and stable until completion.
//  - Completion (bus_valid_o && bus_ready_i): rdata is registered. The rvalid pulse is asserted
//    in the next cycle, in which the FSM is IDLE and can grant again. Latency is bus wait + 2.
//  - if_flush_i during BUSY_I, or in the completion cycle: the transfer still finishes on the
//    bus, but if_rvalid_o is suppressed.
//  - Timeout (TIMEOUT_CYCLES>0): the counter increments each cycle bus_valid_o && !bus_ready_i.
//    When it reaches TIMEOUT_CYCLES: drop bus_valid_o, go to IDLE, and pulse rvalid with
//    err=1 and rdata=0. The counter clears on every grant.
//  - Simultaneous bus_ready_i and timeout in the same cycle: normal completion, err=0.
//  - rst_i mid-transfer: bus_valid_o=0 the next cycle; no rvalid is produced for the lost access.
//  - At most one transfer is outstanding. gnt_o is never asserted outside IDLE.
// TESTING
//  - Lone fetch @0x100, bus_ready after 2 waits -> if_gnt cycle 0, bus_valid cycles 1-3, if_rvalid cycle 4 with bus_rdata.
//  - Both requests in same IDLE cycle, SW @0x2002 wmask 4'b1100 -> dmem granted first, bus_addr 0x2000, we=1, wstrb 1100; fetch granted after dmem_rvalid.
//  - dmem_req held continuously with if_req, MAX_D_BURST=4 -> exactly 4 data grants, then 1 fetch grant, pattern repeats.
//  - Fetch in flight, if_flush_i pulsed -> bus completes, if_rvalid_o stays 0, next grant proceeds normally.
//  - TIMEOUT_CYCLES=8, bus_ready_i stuck low on LW -> bus_valid drops after 8 cycles, dmem_rvalid=1, dmem_err=1, dmem_rdata=0.
//  - rst_i asserted in BUSY_D -> next cycle IDLE, bus_valid_o=0, no dmem_rvalid_o ever for that access.

Source files
------------

// File: rtl/dtcore32_mem_arbiter.sv
// dtcore32_mem_arbiter
//   Shares one 32-bit memory bus between instruction fetch (IF) and load/store (MEM).
//   Only one transfer is outstanding at a time. Data requests normally win. After
//   MAX_D_BURST back-to-back data grants while a fetch waits, the fetch is granted.
//   An optional timeout ends a stalled transfer and reports an error response.
//
// Ports
//   clk_i, rst_i                         clock, synchronous active-high reset
//   if_req_i/if_addr_i/if_flush_i        fetch request, address, discard fetch response
//   if_gnt_o/if_rvalid_o/if_rdata_o/if_err_o   fetch grant, response pulse, data, timeout
//   dmem_req_i/op_i/addr_i/wdata_i/wmask_i     data request and operands
//   dmem_gnt_o/rvalid_o/rdata_o/err_o          data grant, completion pulse, data, timeout
//   bus_valid_o/addr_o/we_o/wstrb_o/wdata_o    bus request side (registered)
//   bus_ready_i/bus_rdata_i                    bus completion and read data
module dtcore32_mem_arbiter #(
  parameter int unsigned MAX_D_BURST    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        dmem_req_i,
  input  logic [4:0]  dmem_op_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  input  logic [3:0]  dmem_wmask_i,
  output logic        dmem_gnt_o,
  output logic        dmem_rvalid_o,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_err_o,
  output logic        bus_valid_o,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_wstrb_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ready_i,
  input  logic [31:0] bus_rdata_i
);

  localparam int BW = $clog2(MAX_D_BURST + 1);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t         state;
  logic [BW-1:0]  burst_cnt;
  logic [TW-1:0]  tcnt;
  logic           drop;      // fetch response of the in-flight fetch is discarded
  logic [31:0]    rdata_q;

  logic idle, burst_full, fetch_pri, done, tmo;

  // Only the low op bits and address LSBs are ignored here; MEM stage owns them.
  logic unused_bits;
  assign unused_bits = ^{dmem_op_i[2:0], if_addr_i[1:0], dmem_addr_i[1:0]};

  assign idle       = (state == IDLE) && !rst_i;
  assign burst_full = (burst_cnt == BW'(MAX_D_BURST));
  // Fetch overrides data only once the burst budget is spent; a flushing fetch never wins.
  assign fetch_pri  = if_req_i && !if_flush_i && burst_full;
  assign dmem_gnt_o = idle && dmem_req_i && !fetch_pri;
  assign if_gnt_o   = idle && if_req_i && !if_flush_i && !dmem_gnt_o;

  assign done = bus_valid_o && bus_ready_i;
  // Ready in the same cycle as the limit counts as a normal completion.
  assign tmo  = (TIMEOUT_CYCLES != 0) && bus_valid_o && !bus_ready_i &&
                (tcnt == TW'(TIMEOUT_CYCLES - 1));

  assign if_rdata_o   = rdata_q;
  assign dmem_rdata_o = rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      burst_cnt     <= '0;
      tcnt          <= '0;
      drop          <= 1'b0;
      rdata_q       <= '0;
      bus_valid_o   <= 1'b0;
      bus_addr_o    <= '0;
      bus_we_o      <= 1'b0;
      bus_wstrb_o   <= '0;
      bus_wdata_o   <= '0;
      if_rvalid_o   <= 1'b0;
      if_err_o      <= 1'b0;
      dmem_rvalid_o <= 1'b0;
      dmem_err_o    <= 1'b0;
    end else begin
      if_rvalid_o   <= 1'b0;
      if_err_o      <= 1'b0;
      dmem_rvalid_o <= 1'b0;
      dmem_err_o    <= 1'b0;

      if (!if_req_i || if_gnt_o)
        burst_cnt <= '0;
      else if (dmem_gnt_o && !burst_full)
        burst_cnt <= burst_cnt + BW'(1);

      case (state)
        IDLE: begin
          if (dmem_gnt_o) begin
            tcnt <= '0;
            if (dmem_op_i[4]) begin
              state       <= BUSY_D;
              bus_valid_o <= 1'b1;
              bus_addr_o  <= {dmem_addr_i[31:2], 2'b00};
              bus_we_o    <= dmem_op_i[3];
              bus_wstrb_o <= dmem_op_i[3] ? dmem_wmask_i : 4'b0000;
              bus_wdata_o <= dmem_wdata_i;
            end else begin
              // Inactive op: acknowledge without touching the bus.
              dmem_rvalid_o <= 1'b1;
              rdata_q       <= '0;
            end
          end else if (if_gnt_o) begin
            tcnt        <= '0;
            drop        <= 1'b0;
            state       <= BUSY_I;
            bus_valid_o <= 1'b1;
            bus_addr_o  <= {if_addr_i[31:2], 2'b00};
            bus_we_o    <= 1'b0;
            bus_wstrb_o <= 4'b0000;
            bus_wdata_o <= '0;
          end
        end
        default: begin
          if (state == BUSY_I && if_flush_i)
            drop <= 1'b1;
          if (done || tmo) begin
            state       <= IDLE;
            bus_valid_o <= 1'b0;
            rdata_q     <= done ? bus_rdata_i : '0;
            if (state == BUSY_I) begin
              if_rvalid_o <= !(drop || if_flush_i);
              if_err_o    <= !done && !(drop || if_flush_i);
            end else begin
              dmem_rvalid_o <= 1'b1;
              dmem_err_o    <= !done;
            end
          end else if (TIMEOUT_CYCLES != 0) begin
            tcnt <= tcnt + TW'(1);
          end
        end
      endcase
    end
  end

endmodule
